// File: rtl/ioctl_load_ctl.sv
// ioctl_load_ctl: routes the ioctl download stream to the ROM loader, the variant byte and the DIP bank,
// and sequences the core reset around ROM downloads.
module ioctl_load_ctl #(
    parameter logic [7:0] ROM_INDEX   = 8'd0,
    parameter logic [7:0] MOD_INDEX   = 8'd1,
    parameter logic [7:0] DIP_INDEX   = 8'd254,
    parameter int         ADDR_W      = 16,
    parameter int         HOLD_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              dn_wr,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic [7:0]        mod,
    output logic [63:0]       sw,
    output logic              core_reset,
    output logic              rom_loaded,
    output logic              rom_ovf,
    output logic              busy
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {RUN, ROM, HOLD, AUX, ABORT} state_t;

    state_t        state;
    logic          dl_q;
    logic [7:0]    idx;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          in_range;

    assign rise     = ioctl_download & ~dl_q;
    assign in_range = (ioctl_addr >> ADDR_W) == '0;
    assign busy     = state != RUN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ABORT;
            dl_q       <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            mod        <= '0;
            sw         <= '1;
            core_reset <= 1'b1;
            rom_loaded <= 1'b0;
            rom_ovf    <= 1'b0;
        end else begin
            dl_q  <= ioctl_download;
            dn_wr <= 1'b0;
            case (state)
                RUN, HOLD: begin
                    if (rise) begin
                        idx   <= ioctl_index;
                        state <= ioctl_index == ROM_INDEX ? ROM : AUX;
                        if (ioctl_index == ROM_INDEX) core_reset <= 1'b1;
                    end else if (state == HOLD) begin
                        if (cnt == '0) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                            rom_loaded <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ROM: begin
                    core_reset <= 1'b1;
                    if (ioctl_wr && in_range) begin
                        dn_wr   <= 1'b1;
                        dn_addr <= ioctl_addr[ADDR_W-1:0];
                        dn_data <= ioctl_dout;
                    end
                    if (ioctl_wr && !in_range) rom_ovf <= 1'b1;
                    if (!ioctl_download) begin
                        state <= HOLD;
                        cnt   <= CW'(HOLD_CYCLES - 1);
                    end
                end
                AUX: begin
                    if (ioctl_wr && idx == MOD_INDEX && ioctl_addr == '0) mod <= ioctl_dout;
                    if (ioctl_wr && idx == DIP_INDEX && ioctl_addr[24:3] == '0) sw[ioctl_addr[2:0]*8 +: 8] <= ioctl_dout;
                    if (!ioctl_download) state <= RUN;
                end
                default: begin
                    // dl_q low here means download was already low as reset released
                    core_reset <= 1'b1;
                    if (!ioctl_download) begin
                        state <= dl_q ? HOLD : RUN;
                        cnt   <= CW'(HOLD_CYCLES - 1);
                    end
                end
            endcase
        end
    end
endmodule
